// File: rtl/dotmatrix_pkg.sv
// Types and constants shared by the dotmatrix image memory and the scroller that feeds it.
package dotmatrix_pkg;
  localparam int ROWS   = 8;
  localparam int COLS   = 8;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam logic [3:0] STRB_VAL = 4'b0001;

  typedef enum logic [1:0] {IDLE, SHIFT, WR_REQ, WR_REL} state_t;

  // win[c][r]: column c (0 = leftmost), row r (0 = top)
  typedef logic [COLS-1:0][ROWS-1:0] window_t;

  function automatic logic [DATA_W-1:0] row_byte(input window_t win, input logic [2:0] row);
    logic [DATA_W-1:0] b;
    b = '0;
    for (int c = 0; c < COLS; c++) b[c] = win[c][row];
    return b;
  endfunction
endpackage

// File: rtl/dm_bus_writer.sv
// Single four-phase CS/Write/ack write master; gives up after ACK_TIMEOUT cycles on either ack edge.
module dm_bus_writer
  import dotmatrix_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              mclock,
  input  logic              mreset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              done,
  output logic              timeout,
  output logic              CS,
  output logic              Write,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] Data_o,
  input  logic              ack
);
  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  state_t            phase_reg, phase_next;
  logic [WAIT_W-1:0] wait_reg;
  logic              cs_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic              expired, load;

  assign expired = (wait_reg == WAIT_LAST);

  always_ff @(posedge mclock or negedge mreset_n) begin
    if (!mreset_n) begin
      phase_reg <= IDLE;
      wait_reg  <= '0;
      cs_reg    <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else begin
      phase_reg <= phase_next;
      // wait count restarts on every phase entry, so each ack edge gets its own budget
      if (phase_next != phase_reg) wait_reg <= '0;
      else if (phase_reg != IDLE)  wait_reg <= wait_reg + 1'b1;
      cs_reg <= (phase_next == WR_REQ);
      if (load) begin
        addr_reg <= addr;
        data_reg <= data;
      end
    end
  end

  always_comb begin
    phase_next = phase_reg;
    case (phase_reg)
      IDLE:    if (start) phase_next = WR_REQ;
      WR_REQ:  if (ack) phase_next = WR_REL;
               else if (expired) phase_next = IDLE;
      WR_REL:  if (!ack) phase_next = start ? WR_REQ : IDLE;
               else if (expired) phase_next = IDLE;
      default: phase_next = IDLE;
    endcase
  end

  always_comb begin
    done    = (phase_reg == WR_REL) && !ack;
    timeout = expired && (((phase_reg == WR_REQ) && !ack) || ((phase_reg == WR_REL) && ack));
    load    = start && ((phase_reg == IDLE) || done);
  end

  assign CS      = cs_reg;
  assign Write   = cs_reg;
  assign Address = addr_reg;
  assign Data_o  = data_reg;
endmodule

// File: rtl/dotmatrix_scroller.sv
// Scrolls an 8x8 column window left once per tick and rewrites all eight rows into dotmatrix.
module dotmatrix_scroller
  import dotmatrix_pkg::*;
#(
  parameter int                SCROLL_DIV  = 2500000,
  parameter int                ACK_TIMEOUT = 255,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 8'h00
) (
  input  logic              mclock,
  input  logic              mreset_n,
  input  logic              enable,
  input  logic              col_valid,
  input  logic [7:0]        col_data,
  output logic              col_ready,
  input  logic              err_clr,
  output logic              CS,
  output logic              Write,
  output logic              Read,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] Data_o,
  output logic [3:0]        STRB,
  input  logic              ack,
  output logic              busy,
  output logic              frame_done,
  output logic              err_timeout,
  output logic              err_overrun
);
  localparam int CNT_W = $clog2(SCROLL_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCROLL_DIV - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [2:0]        row_reg, wr_row;
  window_t           win_reg, win_shifted;
  logic [ROWS-1:0]   col_in;
  logic              pending_reg, err_timeout_reg, err_overrun_reg, frame_done_reg;
  logic              tick, shift_go, frame_end, last_row;
  logic              wr_start, wr_done, wr_timeout;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  assign tick        = enable && (cnt_reg == CNT_LAST);
  assign col_in      = col_valid ? col_data : '0;
  assign win_shifted = {col_in, win_reg[COLS-1:1]};
  assign last_row    = (row_reg == 3'(ROWS - 1));

  always_ff @(posedge mclock or negedge mreset_n) begin
    if (!mreset_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      row_reg         <= '0;
      win_reg         <= '0;
      pending_reg     <= 1'b0;
      err_timeout_reg <= 1'b0;
      err_overrun_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      frame_done_reg <= frame_end;
      cnt_reg        <= (!enable || tick) ? '0 : cnt_reg + 1'b1;
      if (state_reg == SHIFT) begin
        row_reg <= '0;
        win_reg <= win_shifted;
      end else if (wr_start) begin
        row_reg <= wr_row;
      end
      // a tick coinciding with the SHIFT launch of the pending one becomes the new pending tick
      if (!enable)       pending_reg <= 1'b0;
      else if (shift_go) pending_reg <= pending_reg && tick;
      else if (tick)     pending_reg <= 1'b1;
      if (wr_timeout)   err_timeout_reg <= 1'b1;
      else if (err_clr) err_timeout_reg <= 1'b0;
      if (tick && pending_reg && !shift_go) err_overrun_reg <= 1'b1;
      else if (err_clr)                     err_overrun_reg <= 1'b0;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pending_reg || tick) state_next = SHIFT;
      SHIFT:   state_next = WR_REQ;
      WR_REQ:  if (wr_timeout) state_next = IDLE;
               else if (ack) state_next = WR_REL;
      WR_REL:  if (wr_timeout) state_next = IDLE;
               else if (wr_done) state_next = last_row ? IDLE : WR_REQ;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    col_ready = (state_reg == SHIFT);
    busy      = (state_reg != IDLE);
    shift_go  = (state_reg == IDLE) && (pending_reg || tick);
    frame_end = (state_reg == WR_REL) && wr_done && last_row;
    wr_start  = (state_reg == SHIFT) || ((state_reg == WR_REL) && wr_done && !last_row);
    wr_row    = (state_reg == SHIFT) ? 3'd0 : row_reg + 3'd1;
    // row 0 is launched from SHIFT, before win_reg has taken the new column
    wr_data   = row_byte((state_reg == SHIFT) ? win_shifted : win_reg, wr_row);
    wr_addr   = BASE_ADDR + ADDR_W'(wr_row);
  end

  dm_bus_writer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_writer (
    .mclock  (mclock),
    .mreset_n(mreset_n),
    .start   (wr_start),
    .addr    (wr_addr),
    .data    (wr_data),
    .done    (wr_done),
    .timeout (wr_timeout),
    .CS      (CS),
    .Write   (Write),
    .Address (Address),
    .Data_o  (Data_o),
    .ack     (ack)
  );

  assign Read        = 1'b0;
  assign STRB        = STRB_VAL;
  assign frame_done  = frame_done_reg;
  assign err_timeout = err_timeout_reg;
  assign err_overrun = err_overrun_reg;
endmodule
